fifo_flex: RTL and testbench

Parametrised synchronous FIFO, the next generation of the design's ready/valid buffer. Supports any depth ≥ 2, not just powers of two, and uses every entry. Adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and a sticky underflow error. It sits between any producer using `valid_i`/`ready_o` and any consumer using `valid_o`/`yumi_i`, for example between the UART front end and the systolic array's operand loaders.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/ptr_wrap.sv | 33 +++
 rtl/fifo_flex.sv | 92 +++++++++
 tb/tb_fifo_flex.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers for the flexible-depth FIFO and its pointer counters.
package fifo_pkg;

   // Width needed to hold an occupancy from 0 up to and including depth.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Width of an index into depth entries, never narrower than one bit.
   function automatic int ptr_width(input int depth);
      return ($clog2(depth) < 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/ptr_wrap.sv
// Modulo-depth incrementing counter used for the FIFO read and write pointers.
module ptr_wrap
   import fifo_pkg::*;
#(
   parameter int depth_p = 5
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         clear_i,
   input  logic                         en_i,
   output logic [ptr_width(depth_p)-1:0] value_o
);

   localparam int ptr_w = ptr_width(depth_p);
   localparam logic [ptr_w-1:0] last_idx = ptr_w'(depth_p - 1);

   logic [ptr_w-1:0] value_r;

   // Wrap by explicit compare so non-power-of-two depths use every entry.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         value_r <= '0;
      end else if (clear_i) begin
         value_r <= '0;
      end else if (en_i) begin
         if (value_r == last_idx) value_r <= '0;
         else                     value_r <= value_r + ptr_w'(1);
      end
   end

   assign value_o = value_r;

endmodule

// File: rtl/fifo_flex.sv
// Synchronous ready/valid FIFO of any depth >= 2 with occupancy count,
// programmable almost-full/almost-empty flags, flush and sticky underflow.
module fifo_flex
   import fifo_pkg::*;
#(
   parameter int width_p     = 8,
   parameter int depth_p     = 128,
   parameter int af_margin_p = 1,
   parameter int ae_margin_p = 1
) (
   input  logic                          clk_i,
   input  logic                          reset_ni,
   input  logic                          valid_i,
   input  logic [width_p-1:0]            data_i,
   output logic                          ready_o,
   output logic                          valid_o,
   output logic [width_p-1:0]            data_o,
   input  logic                          yumi_i,
   input  logic                          flush_i,
   output logic [cnt_width(depth_p)-1:0] count_o,
   output logic                          almost_full_o,
   output logic                          almost_empty_o,
   output logic                          underflow_o
);

   localparam int cnt_w = cnt_width(depth_p);
   localparam int ptr_w = ptr_width(depth_p);

   logic [width_p-1:0] mem [depth_p];
   logic [cnt_w-1:0]   count_r;
   logic [ptr_w-1:0]   wr_ptr;
   logic [ptr_w-1:0]   rd_ptr;
   logic               underflow_r;
   logic               wr;
   logic               rd;

   assign ready_o = (count_r != cnt_w'(depth_p));
   assign valid_o = (count_r != '0);
   assign wr      = valid_i & ready_o;
   assign rd      = yumi_i & valid_o;

   ptr_wrap #(.depth_p(depth_p)) u_wr_ptr (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clear_i  (flush_i),
      .en_i     (wr),
      .value_o  (wr_ptr)
   );

   ptr_wrap #(.depth_p(depth_p)) u_rd_ptr (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clear_i  (flush_i),
      .en_i     (rd),
      .value_o  (rd_ptr)
   );

   // Storage is deliberately not reset; a write coinciding with flush is dropped.
   always_ff @(posedge clk_i) begin
      if (wr && !flush_i) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         count_r <= '0;
      end else if (flush_i) begin
         count_r <= '0;
      end else if (wr && !rd) begin
         count_r <= count_r + cnt_w'(1);
      end else if (rd && !wr) begin
         count_r <= count_r - cnt_w'(1);
      end
   end

   // Sticky until reset or flush; flush wins over a simultaneous bad yumi.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         underflow_r <= 1'b0;
      end else if (flush_i) begin
         underflow_r <= 1'b0;
      end else if (yumi_i && !valid_o) begin
         underflow_r <= 1'b1;
      end
   end

   assign data_o         = mem[rd_ptr];
   assign count_o        = count_r;
   assign underflow_o    = underflow_r;
   assign almost_full_o  = (int'(count_r) >= (depth_p - af_margin_p));
   assign almost_empty_o = (int'(count_r) <= ae_margin_p);

endmodule

// File: tb/tb_fifo_flex.sv
// Randomised scoreboard bench for fifo_flex at a non-power-of-two depth.
module tb_fifo_flex;

   localparam int width_p     = 8;
   localparam int depth_p     = 5;
   localparam int af_margin_p = 2;
   localparam int ae_margin_p = 1;
   localparam int cnt_w       = $clog2(depth_p + 1);

   logic               clk_i;
   logic               reset_ni;
   logic               valid_i;
   logic [width_p-1:0] data_i;
   logic               ready_o;
   logic               valid_o;
   logic [width_p-1:0] data_o;
   logic               yumi_i;
   logic               flush_i;
   logic [cnt_w-1:0]   count_o;
   logic               almost_full_o;
   logic               almost_empty_o;
   logic               underflow_o;

   int checks;
   int failures;

   logic [width_p-1:0] exp_q[$];
   logic               exp_under;

   fifo_flex #(
      .width_p     (width_p),
      .depth_p     (depth_p),
      .af_margin_p (af_margin_p),
      .ae_margin_p (ae_margin_p)
   ) dut (
      .clk_i          (clk_i),
      .reset_ni       (reset_ni),
      .valid_i        (valid_i),
      .data_i         (data_i),
      .ready_o        (ready_o),
      .valid_o        (valid_o),
      .data_o         (data_o),
      .yumi_i         (yumi_i),
      .flush_i        (flush_i),
      .count_o        (count_o),
      .almost_full_o  (almost_full_o),
      .almost_empty_o (almost_empty_o),
      .underflow_o    (underflow_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic checkBit(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, req);
      end
   endtask

   // Flags are derived from the reference queue's size, not from DUT state.
   task automatic checkOutput();
      int n;
      n = exp_q.size();
      checks++;
      if (int'(count_o) !== n) begin
         failures++;
         $display("[TB] FAIL count at %0t: got %0d expected %0d", $time, count_o, n);
      end
      checkBit("ready", ready_o, n != depth_p);
      checkBit("valid", valid_o, n != 0);
      checkBit("almost_full", almost_full_o, (depth_p - n) <= af_margin_p);
      checkBit("almost_empty", almost_empty_o, n <= ae_margin_p);
      checkBit("underflow", underflow_o, exp_under);
   endtask

   // One cycle: check at the negedge, then drive inputs for the next posedge.
   task automatic applyStimulus(input logic v, input logic [width_p-1:0] d,
                                input logic y, input logic f);
      @(negedge clk_i);
      checkOutput();
      valid_i = v;
      data_i  = d;
      yumi_i  = y;
      flush_i = f;
      if (f) begin
         exp_q.delete();
         exp_under = 1'b0;
      end else begin
         if (y && exp_q.size() == 0) exp_under = 1'b1;
         if (v && exp_q.size() < depth_p) exp_q.push_back(d);
      end
   endtask

   // Monitor: whenever the DUT hands over a head word, pop and compare it.
   initial begin
      forever begin
         @(posedge clk_i);
         if (reset_ni && valid_o && yumi_i && !flush_i) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("[TB] FAIL data at %0t: got %h expected no word", $time, data_o);
            end else begin
               logic [width_p-1:0] exp_d;
               exp_d = exp_q.pop_front();
               if (data_o !== exp_d) begin
                  failures++;
                  $display("[TB] FAIL data at %0t: got %h expected %h", $time, data_o, exp_d);
               end
            end
         end
      end
   end

   task automatic randomPhase(input int cycles, input int wr_pct, input int rd_pct);
      for (int i = 0; i < cycles; i++) begin
         applyStimulus($urandom_range(99) < wr_pct, width_p'($urandom),
                       $urandom_range(99) < rd_pct, $urandom_range(59) == 0);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      exp_under = 1'b0;
      reset_ni  = 1'b0;
      valid_i   = 1'b0;
      data_i    = '0;
      yumi_i    = 1'b0;
      flush_i   = 1'b0;

      @(negedge clk_i);
      @(negedge clk_i);
      checkOutput();
      reset_ni = 1'b1;

      // Fill past full, drain past empty, then mixed traffic.
      for (int i = 1; i <= 6; i++) applyStimulus(1'b1, width_p'(8'h11 * i), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) applyStimulus(1'b1, width_p'(8'h20 + i), 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, width_p'(8'h30 + i), 1'b0, 1'b0);
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b1);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

      randomPhase(400, 80, 30);
      randomPhase(400, 30, 80);
      randomPhase(800, 50, 50);

      // Reach count 4, then drop reset between clock edges.
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, width_p'($urandom), 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput();
      #2;
      reset_ni = 1'b0;
      exp_q.delete();
      exp_under = 1'b0;
      #1;
      checkOutput();
      @(negedge clk_i);
      reset_ni = 1'b1;
      applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      randomPhase(400, 50, 50);
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      @(negedge clk_i);
      checkOutput();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
